param_dcache: RTL and testbench

Parametrised direct-mapped write-through data cache. It sits between the load/store issue stage and the backing data memory. Adds over the previous cache: valid bits, a real miss FSM with a memory handshake, byte-lane LB/SB, a ready/valid request interface, flush, and hit/miss counters. One request is in flight at a time; back-to-back hits run at full rate.

---
 rtl/param_dcache.sv | 204 ++++++++++++++++++++
 tb/tb_param_dcache.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_dcache.sv
// param_dcache: direct-mapped, write-through data cache with one 32-bit word
// per line. Only one miss or store is in flight at a time, and load hits can
// be accepted back to back.
module param_dcache #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int TAG_ID_W = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_pc,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [TAG_ID_W-1:0] req_reg,
  input  logic [3:0]          req_op,
  input  logic [31:0]         req_wdata,
  input  logic                flush,
  output logic                resp_valid,
  output logic [31:0]         resp_pc,
  output logic [TAG_ID_W-1:0] resp_reg,
  output logic [ADDR_W-1:0]   resp_addr,
  output logic [31:0]         resp_data,
  output logic                resp_hit,
  output logic                resp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_be,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, ST_WR, RESP} state_t;

  // Accepted request, held until its response goes out.
  typedef struct packed {
    logic [31:0]         pc;
    logic [ADDR_W-1:0]   addr;
    logic [TAG_ID_W-1:0] rg;
    logic                lb;
    logic                hit;
  } req_t;

  state_t             state;
  req_t               q;
  logic               ready_en;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [31:0]        data_arr [LINES];

  // Decode and lookup of the request presented this cycle.
  logic               is_lb, is_lw, is_sb, is_sw, is_ld, err, hit, accept;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tg;
  logic [31:0]        rd_word, sb_merge;
  logic [3:0]         sb_be;

  assign is_lb   = (req_op == 4'd7);
  assign is_lw   = (req_op == 4'd8);
  assign is_sb   = (req_op == 4'd9);
  assign is_sw   = (req_op == 4'd10);
  assign is_ld   = is_lb | is_lw;
  assign err     = !(is_ld | is_sb | is_sw) | ((is_lw | is_sw) & (req_addr[1:0] != 2'b00));
  assign idx     = req_addr[INDEX_W+1:2];
  assign tg      = req_addr[ADDR_W-1:INDEX_W+2];
  assign rd_word = data_arr[idx];
  assign hit     = valid[idx] && (tag_arr[idx] == tg);
  assign sb_be   = 4'b0001 << req_addr[1:0];

  assign req_ready = ready_en && (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  assign resp_pc   = q.pc;
  assign resp_reg  = q.rg;
  assign resp_addr = q.addr;

  // SB hit: replace only the addressed byte lane of the cached word.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign sb_merge[b*8 +: 8] = sb_be[b] ? req_wdata[7:0] : rd_word[b*8 +: 8];
  end

  function automatic logic [31:0] lane_sel(input logic [31:0] w, input logic [1:0] off,
                                           input logic lb);
    lane_sel = lb ? {24'd0, w[{off, 3'b000} +: 8]} : w;
  endfunction

  // Single array write port: SW allocate, SB-hit merge, or miss fill.
  logic               arr_we;
  logic [INDEX_W-1:0] arr_idx;
  logic [TAG_W-1:0]   arr_tag;
  logic [31:0]        arr_data;
  always_comb begin
    arr_we   = 1'b0;
    arr_idx  = idx;
    arr_tag  = tg;
    arr_data = req_wdata;
    if (accept && is_sw && !err) begin
      arr_we = 1'b1;
    end else if (accept && is_sb && hit) begin
      arr_we   = 1'b1;
      arr_data = sb_merge;
    end else if (state == RD_MISS && mem_ack) begin
      arr_we   = 1'b1;
      arr_idx  = q.addr[INDEX_W+1:2];
      arr_tag  = q.addr[ADDR_W-1:INDEX_W+2];
      arr_data = mem_rdata;
    end
  end

  // Tag/data storage: no reset, the valid bits qualify contents.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_arr[arr_idx]  <= arr_tag;
      data_arr[arr_idx] <= arr_data;
    end
  end

  // Control FSM, valid bits, memory handshake, response and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      q          <= '0;
      ready_en   <= 1'b0;
      valid      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      ready_en   <= 1'b1;
      resp_valid <= 1'b0;
      if (arr_we) valid[arr_idx] <= 1'b1;
      case (state)
        IDLE: begin
          if (flush && ready_en) begin
            valid <= '0;
          end else if (accept) begin
            q         <= '{pc: req_pc, addr: req_addr, rg: req_reg, lb: is_lb, hit: hit};
            resp_err  <= err;
            resp_hit  <= 1'b0;
            resp_data <= '0;
            if (err) begin
              resp_valid <= 1'b1;
            end else if (is_ld && hit) begin
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              resp_data  <= lane_sel(rd_word, req_addr[1:0], is_lb);
              if (!(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
            end else if (is_ld) begin
              state     <= RD_MISS;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_be    <= 4'hF;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= '0;
              if (!(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
            end else begin
              state     <= ST_WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_be    <= is_sw ? 4'hF : sb_be;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= is_sw ? req_wdata : {4{req_wdata[7:0]}};
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_data  <= lane_sel(mem_rdata, q.addr[1:0], q.lb);
            state      <= RESP;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_hit   <= q.hit;
            resp_data  <= '0;
            state      <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_dcache.sv
// tb_param_dcache: directed test-plan sequences plus randomized traffic,
// checked against a word-level memory model and a line valid/tag model.
module tb_param_dcache;
  localparam int ADDR_W = 32, INDEX_W = 8, TAG_ID_W = 6, CNT_W = 16;
  localparam int TSH = INDEX_W + 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                clk = 1'b0, rstn = 1'b0;
  logic                req_valid = 1'b0, req_ready;
  logic [31:0]         req_pc = '0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [TAG_ID_W-1:0] req_reg = '0;
  logic [3:0]          req_op = '0;
  logic [31:0]         req_wdata = '0;
  logic                flush = 1'b0;
  logic                resp_valid, resp_hit, resp_err;
  logic [31:0]         resp_pc, resp_data;
  logic [TAG_ID_W-1:0] resp_reg;
  logic [ADDR_W-1:0]   resp_addr, mem_addr;
  logic                mem_req, mem_we, mem_ack;
  logic [31:0]         mem_wdata, mem_rdata;
  logic [3:0]          mem_be;
  logic [CNT_W-1:0]    hit_cnt, miss_cnt;

  param_dcache #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .TAG_ID_W(TAG_ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_addr(req_addr), .req_reg(req_reg), .req_op(req_op),
    .req_wdata(req_wdata), .flush(flush), .resp_valid(resp_valid), .resp_pc(resp_pc),
    .resp_reg(resp_reg), .resp_addr(resp_addr), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory model, word-addressed, deterministic default contents.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Cache model: which tag each index currently holds.
  bit          cvalid [int];
  logic [31:0] ctag   [int];
  int          m_hits = 0, m_misses = 0;

  // Memory responder: acks ack_dly cycles after mem_req is first seen.
  int          ack_dly = 1, wcnt = 0, txn_cnt = 0, ack_cyc = 0;
  logic [36:0] f_ctl;
  logic [31:0] f_wdata, last_wdata;
  logic [31:0] last_addr;
  logic        last_we;
  logic [3:0]  last_be;
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) wcnt = 0;
      else begin
        if (wcnt == 0) begin
          f_ctl = {mem_we, mem_be, mem_addr};
          f_wdata = mem_wdata;
        end
        if (wcnt >= ack_dly) begin
          chk("mem_ctl_stable", {mem_we, mem_be, mem_addr}, f_ctl);
          chk("mem_wdata_stable", mem_wdata, f_wdata);
          last_we = mem_we; last_be = mem_be; last_addr = mem_addr; last_wdata = mem_wdata;
          if (mem_we) begin
            logic [31:0] w;
            w = memrd(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem[{mem_addr[31:2], 2'b00}] = w;
            mem_rdata = $urandom;
          end else mem_rdata = memrd(mem_addr);
          mem_ack = 1'b1;
          txn_cnt++;
          ack_cyc = cyc;
          wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // One complete request: issue, wait for the response, check it, update model.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] gdata, output logic ghit);
    logic [31:0] pc, w, exp_data, tg;
    logic [5:0]  rg;
    int          idx, n, t0;
    bit          is_ld, is_st, err, hit, fast;
    pc = $urandom; rg = 6'($urandom);
    idx = int'(addr[TSH-1:2]); tg = addr >> TSH;
    is_ld = (op == 7) || (op == 8);
    is_st = (op == 9) || (op == 10);
    err = !(is_ld || is_st) || (((op == 8) || (op == 10)) && addr[1:0] != 0);
    hit = cvalid.exists(idx) && (ctag[idx] == tg);
    w = memrd(addr);
    exp_data = (err || is_st) ? 32'd0 : ((op == 7) ? ((w >> (8 * addr[1:0])) & 32'hFF) : w);
    fast = err || (is_ld && hit);
    t0 = txn_cnt;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc; req_reg = rg;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_next_cycle", resp_valid, fast);
    chk("mem_req_next_cycle", mem_req, !fast);
    chk("ready_during", req_ready, fast);
    n = 0;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("rsp_seen", resp_valid, 1'b1);
    if (!fast) chk("rsp_latency", cyc, ack_cyc + 1);
    chk("mem_txn_count", txn_cnt - t0, fast ? 0 : 1);
    chk("rsp_data", resp_data, exp_data);
    chk("rsp_hit", resp_hit, err ? 1'b0 : hit);
    chk("rsp_err", resp_err, err);
    chk("rsp_echo", {resp_pc, resp_reg}, {pc, rg});
    chk("rsp_addr", resp_addr, addr);
    gdata = resp_data; ghit = resp_hit;
    if (!fast) begin
      chk("mem_txn", {last_we, last_be, last_addr},
          {is_st, (op == 9) ? (4'b0001 << addr[1:0]) : 4'hF, addr & ~32'd3});
      if (is_st) chk("mem_wdata", last_wdata, (op == 10) ? wd : {4{wd[7:0]}});
    end
    @(negedge clk);
    chk("rsp_pulse", resp_valid, 1'b0);
    if (!err) begin
      if (is_ld && hit) m_hits = (m_hits == CMAX) ? CMAX : m_hits + 1;
      if (is_ld && !hit) m_misses = (m_misses == CMAX) ? CMAX : m_misses + 1;
      if (op == 10 || (is_ld && !hit)) begin cvalid[idx] = 1'b1; ctag[idx] = tg; end
    end
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_blocks_ready", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    cvalid.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] gd;
    logic        gh;
    logic [31:0] b2b [4];
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_outputs", {resp_valid, resp_hit, resp_err, mem_req, mem_we}, 5'd0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);

    // Load miss fill then hit
    mem[32'h100] = 32'hDEADBEEF;
    ack_dly = 3;
    access(4'd8, 32'h100, 0, gd, gh);
    chk("tp1_miss_data", gd, 32'hDEADBEEF);
    chk("tp1_miss_hit", gh, 1'b0);
    access(4'd8, 32'h100, 0, gd, gh);
    chk("tp1_hit", {gh, gd}, {1'b1, 32'hDEADBEEF});

    // SW allocate, LB hit
    ack_dly = 1;
    access(4'd10, 32'h200, 32'h11223344, gd, gh);
    access(4'd7, 32'h203, 0, gd, gh);
    chk("tp2_lb", {gh, gd}, {1'b1, 32'h11});

    // SB merge on a hit
    access(4'd9, 32'h201, 32'h000000AB, gd, gh);
    chk("tp3_sb_be", {last_be, last_wdata}, {4'b0010, 32'hABABABAB});
    access(4'd8, 32'h200, 0, gd, gh);
    chk("tp3_lw", {gh, gd}, {1'b1, 32'h1122AB44});

    // Aliasing on the same index
    access(4'd8, 32'h100 + (32'd1 << TSH), 0, gd, gh);
    chk("tp4_alias_miss", gh, 1'b0);
    access(4'd8, 32'h100, 0, gd, gh);
    chk("tp4_back_miss", gh, 1'b0);

    // Four back-to-back hits
    b2b[0] = 32'h100; b2b[1] = 32'h200; b2b[2] = 32'h203; b2b[3] = 32'h100;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_op = (i == 2) ? 4'd7 : 4'd8; req_addr = b2b[i];
      @(negedge clk);
      chk("b2b_rsp", {resp_valid, resp_hit}, 2'b11);
      chk("b2b_data", resp_data,
          (i == 2) ? ((memrd(b2b[i]) >> 24) & 32'hFF) : memrd(b2b[i]));
    end
    req_valid = 1'b0;
    m_hits += 4;
    @(negedge clk);
    chk("b2b_hit_cnt", hit_cnt, m_hits);
    do_flush();
    access(4'd8, 32'h100, 0, gd, gh);
    chk("tp5_flush_miss", gh, 1'b0);

    // Reset in the middle of a miss
    ack_dly = 40;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd8; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("tp6_memreq", mem_req, 1'b1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk("tp6_memreq_drop", {mem_req, resp_valid, req_ready}, 3'b000);
    chk("tp6_cnts", {hit_cnt, miss_cnt}, 32'd0);
    cvalid.delete(); m_hits = 0; m_misses = 0;
    repeat (2) @(negedge clk);
    chk("tp6_no_rsp", resp_valid, 1'b0);
    rstn = 1'b1;
    ack_dly = 1;
    access(4'd8, 32'h300, 0, gd, gh);
    chk("tp6_after_rst_miss", gh, 1'b0);
    access(4'd8, 32'h100, 0, gd, gh);
    chk("tp6_prior_miss", gh, 1'b0);
    access(4'd3, 32'h100, 0, gd, gh);
    access(4'd8, 32'h102, 0, gd, gh);

    // Randomized traffic over a few indices and aliasing tags
    for (int it = 0; it < 200; it++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 99);
      if (r < 4) do_flush();
      else begin
        op = (r < 9) ? 4'($urandom_range(0, 15)) : 4'(7 + $urandom_range(0, 3));
        a = (32'($urandom_range(0, 2)) << TSH) | (32'($urandom_range(0, 3)) << 2);
        if (op == 7 || op == 9 || $urandom_range(0, 9) == 0) a = a | 32'($urandom_range(0, 3));
        ack_dly = $urandom_range(0, 3);
        access(op, a, $urandom, gd, gh);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
